axo32_fetch: RTL and testbench

Instruction fetch unit for the RV32 core: owns the fetch PC, issues word reads on the instruction bus, buffers returned words, and presents them with their PC to the instruction decoder through a valid/ready handshake. Sits between the instruction memory port and the decoder. Accepts PC redirects from branch, jump and trap logic, and discards in-flight fetches that a redirect makes stale.

---
 rtl/axo32_fetch.sv | 91 +++++++++
 tb/tb_axo32_fetch.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/axo32_fetch.sv
// axo32_fetch: RV32 instruction fetch unit with single-outstanding bus reads, redirect/discard and fault entries.
// Define AXO_FETCH_PREFETCH_EN for a 2-deep prefetch buffer; otherwise a single holding register.
module axo32_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        bus_re,
  output logic [31:0] bus_addr,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  input  logic        redir,
  input  logic [31:0] redir_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        inst_ready
);
`ifdef AXO_FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  typedef enum logic [1:0] {IDLE, REQ, HALT} state_t;
  state_t      r_state;
  logic [31:0] r_fpc, r_addr;
  logic        r_discard;
  logic [1:0]  r_count;
  logic [64:0] r_head;
  logic        w_hold, w_ack, w_take, w_ok, w_ferr, w_dmis, w_rmis, w_push, w_pop, w_room;
  logic [1:0]  w_next_count;
  logic [31:0] w_fpc_n;
  logic [64:0] w_din;
  // w_hold: a request is outstanding and not answered this cycle, so bus_addr must stay put
  assign w_hold = r_state == REQ && !bus_ack;
  assign w_ack  = r_state == REQ && bus_ack;
  assign w_take = w_ack && !r_discard && !redir;
  assign w_ok   = w_take && !bus_err;
  assign w_ferr = w_take && bus_err;
  assign w_dmis = w_ack && r_discard && !redir && r_fpc[1:0] != 2'd0;
  assign w_rmis = redir && !w_hold && redir_pc[1:0] != 2'd0;
  assign w_push = w_ok || w_ferr || w_dmis || w_rmis;
  assign w_din  = w_ok ? {bus_rdata, r_fpc, 1'b0} : {32'd0, w_rmis ? redir_pc : r_fpc, 1'b1};
  assign w_pop  = inst_valid && inst_ready && !redir;
  assign w_next_count = redir ? {1'b0, w_push} : r_count + {1'b0, w_push} - {1'b0, w_pop};
  assign w_room  = w_next_count < 2'(DEPTH);
  assign w_fpc_n = redir ? redir_pc : w_ok ? r_fpc + 32'd4 : r_fpc;
  assign bus_re     = r_state == REQ;
  assign bus_addr   = r_addr;
  assign inst_valid = r_count != 2'd0;
  assign {inst, inst_pc, inst_fault} = r_head;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= IDLE;
      r_fpc     <= RESET_VECTOR;
      r_addr    <= RESET_VECTOR;
      r_discard <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      r_state   <= redir ? (w_rmis ? HALT : REQ) :
                   r_state == IDLE ? (w_room ? REQ : IDLE) :
                   r_state == HALT ? HALT :
                   w_hold ? REQ :
                   (w_dmis || w_ferr) ? HALT :
                   (r_discard || w_room) ? REQ : IDLE;
      r_fpc     <= w_fpc_n;
      r_addr    <= w_hold ? r_addr : w_fpc_n;
      r_discard <= redir ? w_hold : (w_ack ? 1'b0 : r_discard);
      r_count   <= w_next_count;
    end
`ifdef AXO_FETCH_PREFETCH_EN
  logic [64:0] r_tail;
  logic [1:0]  w_wp;
  assign w_wp = redir ? 2'd0 : r_count - {1'b0, w_pop};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push && w_wp == 2'd1) r_tail <= w_din;
      if (w_push && w_wp == 2'd0) r_head <= w_din;
      else if (w_pop) r_head <= r_tail;
    end
`else
  always_ff @(posedge clk or posedge rst)
    if (rst) r_head <= '0;
    else if (w_push) r_head <= w_din;
`endif
endmodule

// File: tb/tb_axo32_fetch.sv
// tb_axo32_fetch: scoreboard bench for axo32_fetch with a behavioural instruction bus.
module tb_axo32_fetch;
  localparam logic [31:0] RV = 32'h100;
`ifdef AXO_FETCH_PREFETCH_EN
  localparam int PER = 1;
`else
  localparam int PER = 2;
`endif
  logic        clk = 0, rst = 1;
  logic        bus_re, bus_ack, bus_err, redir, inst_valid, inst_fault, inst_ready;
  logic [31:0] bus_addr, bus_rdata, redir_pc, inst, inst_pc;
  int n_chk = 0, n_err = 0, n_acc = 0, cyc = 0, wait_n = 0, wcnt = 0;
  int acc_cyc [64];
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic [64:0] exp_q [$];

  axo32_fetch #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .rst(rst), .bus_re(bus_re), .bus_addr(bus_addr), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .bus_err(bus_err), .redir(redir), .redir_pc(redir_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault),
    .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] wd(input logic [31:0] a);
    return a ^ 32'hA5A5A5A5;
  endfunction

  // bus responder: acks after wait_n idle cycles, data derived from the address
  always @(negedge clk) begin
    bus_ack = 1'b0;
    bus_err = 1'b0;
    if (bus_re) begin
      if (wcnt >= wait_n) begin
        bus_ack   = 1'b1;
        bus_rdata = wd(bus_addr);
        bus_err   = bus_addr == err_addr;
        wcnt      = 0;
      end else wcnt++;
    end else wcnt = 0;
  end

  // monitor: every accepted handshake must match the head of the expectation queue
  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready && !redir) begin
      logic [64:0] e;
      if (n_acc < 64) acc_cyc[n_acc] = cyc;
      n_acc++;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL entry: unexpected inst=%h pc=%h fault=%b, want none", inst, inst_pc, inst_fault);
      end else begin
        e = exp_q.pop_front();
        if ({inst, inst_pc, inst_fault} !== e) begin
          n_err++;
          $display("FAIL entry: got inst=%h pc=%h fault=%b, want inst=%h pc=%h fault=%b",
                   inst, inst_pc, inst_fault, e[64:33], e[32:1], e[0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic wait_acc(input int n);
    int k = 0;
    while (n_acc < n && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_chk++;
    if (n_acc < n) begin
      n_err++;
      $display("FAIL wait_acc: got %0d accepts, want %0d", n_acc, n);
    end
    tick();
  endtask

  task automatic push_ok(input logic [31:0] a);
    exp_q.push_back({wd(a), a, 1'b0});
  endtask

  task automatic pulse_redir(input logic [31:0] pc);
    redir    = 1'b1;
    redir_pc = pc;
    tick();
    redir    = 1'b0;
  endtask

  initial begin
    inst_ready = 0; redir = 0; redir_pc = 0; bus_ack = 0; bus_err = 0; bus_rdata = 0;
    repeat (3) tick();
    chk("rst_bus_re", 32'(bus_re), 0);
    chk("rst_bus_addr", bus_addr, RV);
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_fault", 32'(inst_fault), 0);
    // streaming from the reset vector, then backpressure
    for (int a = 0; a < 16; a++) push_ok(RV + 32'(4 * a));
    rst = 0;
    inst_ready = 1;
    tick();
    chk("first_re", 32'(bus_re), 1);
    chk("first_addr", bus_addr, RV);
    chk("first_valid", 32'(inst_valid), 0);
    tick();
    chk("ack_valid", 32'(inst_valid), 1);
    chk("ack_pc", inst_pc, RV);
    wait_acc(12);
    inst_ready = 0;
    chk("throughput", 32'(acc_cyc[11] - acc_cyc[0]), 32'(11 * PER));
    repeat (10) tick();
    chk("full_re", 32'(bus_re), 0);
    chk("full_valid", 32'(inst_valid), 1);
    chk("full_pc", inst_pc, 32'h130);
    inst_ready = 1;
    wait_acc(16);
    inst_ready = 0;
    repeat (6) tick();
    // redirect while a slow request is outstanding
    wait_n = 3;
    pulse_redir(32'h300);
    chk("redir_re", 32'(bus_re), 1);
    chk("redir_addr", bus_addr, 32'h300);
    pulse_redir(32'h2000);
    chk("hold_addr0", bus_addr, 32'h300);
    tick();
    chk("hold_addr1", bus_addr, 32'h300);
    tick();
    chk("hold_addr2", bus_addr, 32'h300);
    wait_n = 0;
    tick();
    chk("post_discard_addr", bus_addr, 32'h2000);
    push_ok(32'h2000); push_ok(32'h2004); push_ok(32'h2008);
    inst_ready = 1;
    wait_acc(19);
    inst_ready = 0;
    repeat (6) tick();
    // redirect coincident with an ack, then a bus error
    push_ok(32'h200C);
    push_ok(32'h108);
    exp_q.push_back({32'd0, 32'h10C, 1'b1});
    err_addr = 32'h10C;
    inst_ready = 1;
    tick();
    chk("coinc_re", 32'(bus_re), 1);
    pulse_redir(32'h108);
    chk("coinc_re2", 32'(bus_re), 1);
    chk("coinc_addr", bus_addr, 32'h108);
    wait_acc(22);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("halt_re", 32'(bus_re), 0);
    end
    chk("halt_valid", 32'(inst_valid), 0);
    // resume at 0, then misaligned redirect
    push_ok(32'h0); push_ok(32'h4); push_ok(32'h8);
    pulse_redir(32'h0);
    chk("resume_re", 32'(bus_re), 1);
    chk("resume_addr", bus_addr, 32'h0);
    wait_acc(25);
    inst_ready = 0;
    repeat (6) tick();
    exp_q.push_back({32'd0, 32'h102, 1'b1});
    pulse_redir(32'h102);
    chk("mis_re", 32'(bus_re), 0);
    chk("mis_valid", 32'(inst_valid), 1);
    chk("mis_fault", 32'(inst_fault), 1);
    inst_ready = 1;
    wait_acc(26);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mis_halt_re", 32'(bus_re), 0);
    end
    // PC wrap
    push_ok(32'hFFFF_FFFC); push_ok(32'h0); push_ok(32'h4);
    pulse_redir(32'hFFFF_FFFC);
    chk("wrap_addr", bus_addr, 32'hFFFF_FFFC);
    wait_acc(29);
    inst_ready = 0;
    // reset abandons an outstanding request
    pulse_redir(32'h400);
    wait_n = 5;
    chk("pre_rst_addr", bus_addr, 32'h400);
    tick();
    chk("pre_rst_re", 32'(bus_re), 1);
    rst = 1;
    #1;
    chk("mid_rst_re", 32'(bus_re), 0);
    chk("mid_rst_addr", bus_addr, RV);
    chk("mid_rst_valid", 32'(inst_valid), 0);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
